// File: rtl/sobel_readback.sv
// Streams one Sobel result layer out of the layered memory through a small
// ready/valid FIFO, accumulating a checksum and the maximum transferred pixel.
module sobel_readback #(
  parameter int NPIX   = 64516,
  parameter int FDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  layer,
  output logic        busy,
  output logic        crd,
  output logic [1:0]  csel,
  output logic [15:0] caddr_rd,
  input  logic [7:0]  cdata_rd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        err,
  output logic [23:0] checksum,
  output logic [7:0]  max_pix
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] LAST_ADDR = 16'(NPIX - 1);
  localparam logic [CW:0] DEPTH     = (CW + 1)'(FDEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  state_t state, next_state;

  logic [1:0]    lay_q;
  logic [15:0]   addr;
  logic [15:0]   addr_hold;
  logic          rd_pend;
  logic          err_q;
  logic [7:0]    mem [FDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          accept;
  logic          issue;
  logic          room;
  logic          push;
  logic          pop;

  // A read may only be issued if its data is guaranteed a FIFO slot on return.
  assign room = ({1'b0, count} + {{CW{1'b0}}, rd_pend}) < DEPTH;
  assign push = rd_pend;
  assign pop  = out_valid && out_ready;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start && (layer != 2'b00)) begin
          accept     = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        issue = room;
        if (issue && (addr == LAST_ADDR)) next_state = DRAIN;
      end
      DRAIN: begin
        if (!rd_pend && (count == '0)) next_state = FIN;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign crd       = issue;
  assign csel      = issue ? lay_q : 2'b00;
  assign caddr_rd  = issue ? addr : addr_hold;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign err       = err_q;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lay_q     <= 2'b00;
      addr      <= '0;
      addr_hold <= '0;
      rd_pend   <= 1'b0;
      err_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      checksum  <= '0;
      max_pix   <= '0;
    end else begin
      err_q   <= (state == IDLE) && start && (layer == 2'b00);
      rd_pend <= issue;
      if (issue) begin
        addr      <= addr + 16'd1;
        addr_hold <= addr;
      end
      if (accept) begin
        lay_q    <= layer;
        addr     <= '0;
        checksum <= '0;
        max_pix  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + AW'(1);
          checksum <= checksum + {16'd0, out_data};
          if (out_data > max_pix) max_pix <= out_data;
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is cleared on reset so out_data reads zero while held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FDEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= cdata_rd;
    end
  end

endmodule

// File: tb/tb_sobel_readback.sv
// Self-checking bench for sobel_readback: table-driven readbacks with a pixel
// scoreboard, plus reset-abort and full-size (64516 pixel) sequences.
module tb_sobel_readback;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  layer = 2'b00;
  logic        out_ready = 1'b1;
  logic [7:0]  cdata_rd = 8'h00;
  logic        busy, crd, out_valid, done, err;
  logic [1:0]  csel;
  logic [15:0] caddr_rd;
  logic [7:0]  out_data, max_pix;
  logic [23:0] checksum;

  logic        start_b = 1'b0;
  logic [1:0]  layer_b = 2'b11;
  logic [7:0]  cdata_b = 8'hFF;
  logic        ready_b = 1'b1;
  logic        busy_b, crd_b, valid_b, done_b, err_b;
  logic [1:0]  csel_b;
  logic [15:0] caddr_b;
  logic [7:0]  data_b, max_b;
  logic [23:0] sum_b;

  always #5 clk = ~clk;

  sobel_readback #(.NPIX(16), .FDEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .busy(busy),
    .crd(crd), .csel(csel), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err), .checksum(checksum), .max_pix(max_pix)
  );

  sobel_readback #(.NPIX(64516), .FDEPTH(4)) dut_big (
    .clk(clk), .reset(reset), .start(start_b), .layer(layer_b), .busy(busy_b),
    .crd(crd_b), .csel(csel_b), .caddr_rd(caddr_b), .cdata_rd(cdata_b),
    .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
    .done(done_b), .err(err_b), .checksum(sum_b), .max_pix(max_b)
  );

  typedef struct {
    logic [1:0]  layer;
    bit          rand_ready;
    bit          extra_start;
    logic [23:0] exp_sum;
    logic [7:0]  exp_max;
  } vec_t;

  vec_t        vecs [6];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q [$];
  logic [1:0]  exp_layer = 2'b00;
  bit          rand_ready = 1'b0;
  int          xfers = 0, sb_err = 0, csel_err = 0, occ_err = 0, stall_err = 0;
  int          outstanding = 0;
  bit          held = 1'b0;
  logic [7:0]  held_data = 8'h00;
  logic [7:0]  exp_pix;

  function automatic logic [7:0] pix(input logic [1:0] l, input int a);
    case (l)
      2'b01:   return 8'(a * 3);
      2'b10:   return 8'(a * 5 + 1);
      2'b11:   return 8'(a * 7 + 2);
      default: return 8'h00;
    endcase
  endfunction

  // Layered memory: data appears the cycle after the read strobe.
  always @(posedge clk) cdata_rd <= crd ? pix(csel, int'(caddr_rd)) : 8'h00;

  // Sink and protocol monitor; out_ready is chosen before the transfer test.
  always @(negedge clk) begin
    out_ready = rand_ready ? ($urandom_range(99) < 30) : 1'b1;
    if (!reset) begin
      outstanding = 0;
      held = 1'b0;
    end else begin
      if (crd && csel != exp_layer) begin
        csel_err++;
        $display("[TB] FAIL csel_on_read: got %0d, expected %0d", csel, exp_layer);
      end
      if (!crd && csel != 2'b00) begin
        csel_err++;
        $display("[TB] FAIL csel_idle: got %0d, expected 0", csel);
      end
      if (crd && outstanding >= 4) begin
        occ_err++;
        $display("[TB] FAIL outstanding: got %0d, expected below 4", outstanding);
      end
      if (held && (!out_valid || out_data != held_data)) begin
        stall_err++;
        $display("[TB] FAIL stall_hold: got %0d/%0d, expected 1/%0d", out_valid, out_data, held_data);
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (crd) outstanding++;
      if (out_valid && out_ready) begin
        xfers++;
        outstanding--;
        if (exp_q.size() == 0) begin
          sb_err++;
          $display("[TB] FAIL sb_extra: got %0d, expected no transfer", out_data);
        end else begin
          exp_pix = exp_q.pop_front();
          if (out_data != exp_pix) begin
            sb_err++;
            $display("[TB] FAIL sb_pixel: got %0d, expected %0d", out_data, exp_pix);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input logic [23:0] prev_sum, input logic [7:0] prev_max);
    int sb0 = sb_err, cs0 = csel_err, oc0 = occ_err, st0 = stall_err;
    int n = 0, first_v = -1, last_v = -1, valid_cnt = 0;
    int done_cnt = 0, done_n = -1, err_cnt = 0, err_n = -1, act_cnt = 0;
    bit busy_at_done = 1'b0, busy_after = 1'b1;
    exp_q.delete();
    exp_layer = v.layer;
    rand_ready = v.rand_ready;
    if (v.layer != 2'b00) for (int a = 0; a < 16; a++) exp_q.push_back(pix(v.layer, a));
    @(negedge clk);
    start = 1'b1;
    layer = v.layer;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (v.extra_start && n == 8) begin start = 1'b1; layer = 2'b10; end
      if (v.extra_start && n == 9) start = 1'b0;
      if (out_valid) begin
        valid_cnt++;
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      if (crd || out_valid || busy) act_cnt++;
      if (err) begin err_cnt++; err_n = n; end
      if (done) begin done_cnt++; done_n = n; busy_at_done = busy; end
      if (done_n > 0 && n == done_n + 1) begin busy_after = busy; break; end
      if (v.layer == 2'b00 && n == 6) break;
    end
    if (v.layer != 2'b00) begin
      check_output("done_pulses", done_cnt, 1);
      check_output("busy_at_done", busy_at_done, 1);
      check_output("busy_after_done", busy_after, 0);
      check_output("checksum", checksum, v.exp_sum);
      check_output("max_pix", max_pix, v.exp_max);
      check_output("pixels_left", exp_q.size(), 0);
      check_output("sb_errors", sb_err - sb0, 0);
      check_output("csel_errors", csel_err - cs0, 0);
      check_output("occupancy_errors", occ_err - oc0, 0);
      check_output("stall_errors", stall_err - st0, 0);
      check_output("err_pulses", err_cnt, 0);
      if (!v.rand_ready) begin
        check_output("first_valid_cycle", first_v, 3);
        check_output("stream_span", last_v - first_v, 15);
        check_output("valid_cycles", valid_cnt, 16);
      end
    end else begin
      check_output("err_pulses", err_cnt, 1);
      check_output("err_cycle", err_n, 1);
      check_output("activity_on_err", act_cnt, 0);
      check_output("done_on_err", done_cnt, 0);
      check_output("checksum_held", checksum, prev_sum);
      check_output("max_held", max_pix, prev_max);
    end
  endtask

  initial begin
    int x0, n, big_x, big_done, last_addr;
    vecs[0] = '{2'b01, 1'b0, 1'b0, 24'd360, 8'd45};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 24'd360, 8'd45};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 24'd616, 8'd76};
    vecs[3] = '{2'b11, 1'b0, 1'b0, 24'd872, 8'd107};
    vecs[4] = '{2'b00, 1'b0, 1'b0, 24'd0,   8'd0};
    vecs[5] = '{2'b11, 1'b1, 1'b1, 24'd872, 8'd107};

    #12;
    check_output("reset_busy", busy, 0);
    check_output("reset_valid", out_valid, 0);
    check_output("reset_checksum", checksum, 0);
    @(posedge clk); #2 reset = 1'b1;

    for (int i = 0; i < 6; i++)
      apply_stimulus(vecs[i], (i > 0) ? vecs[i-1].exp_sum : 24'd0, (i > 0) ? vecs[i-1].exp_max : 8'd0);

    // Abort a readback of layer 01 right after its 5th transfer.
    exp_q.delete();
    exp_layer = 2'b01;
    rand_ready = 1'b0;
    for (int a = 0; a < 16; a++) exp_q.push_back(pix(2'b01, a));
    x0 = xfers;
    @(negedge clk); start = 1'b1; layer = 2'b01;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (xfers - x0 < 5 && n < 100) begin @(negedge clk); n++; end
    check_output("abort_reached", xfers - x0, 5);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check_output("abort_busy", busy, 0);
    check_output("abort_crd", crd, 0);
    check_output("abort_valid", out_valid, 0);
    check_output("abort_done", done, 0);
    check_output("abort_err", err, 0);
    check_output("abort_csel", csel, 0);
    check_output("abort_caddr", caddr_rd, 0);
    check_output("abort_data", out_data, 0);
    check_output("abort_checksum", checksum, 0);
    check_output("abort_max", max_pix, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    apply_stimulus('{2'b10, 1'b0, 1'b0, 24'd616, 8'd76}, 24'd0, 8'd0);

    // Full-size layer of all-255 pixels.
    big_x = 0; big_done = 0; last_addr = -1;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (big_done == 0 && n < 70000) begin
      if (valid_b) big_x++;
      if (crd_b) last_addr = int'(caddr_b);
      if (done_b) big_done++;
      @(negedge clk);
      n++;
    end
    check_output("big_done", big_done, 1);
    check_output("big_transfers", big_x, 64516);
    check_output("big_last_addr", last_addr, 64515);
    check_output("big_checksum", sum_b, 16451580);
    check_output("big_max", max_b, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
